cache_req_arbiter: RTL

Round-robin arbiter sharing one LRU-cache pipeline between NUM_REQ requesters. Accepts tag lookups from requester address streams, forwards one per cycle into the cache frontend address stream and records the requester ID in an in-order tracking FIFO. Routes each returning cache data beat back to the requester that issued it. Sits between per-queue lookup clients in the 250 MHz box and the cache frontend.

---
 rtl/cache_req_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache pipeline between NUM_REQ requesters, with in-order response routing.
// Optional per-requester grant counters when CACHE_ARB_PERF_EN is defined.
module cache_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TAGS_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int ORDER_DEPTH = 8,
    parameter int IDW         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr_tdata,
    input  logic [NUM_REQ-1:0]            req_addr_tvalid,
    output logic [NUM_REQ-1:0]            req_addr_tready,
    output logic [DATA_WIDTH-1:0]         rsp_data_tdata,
    output logic [NUM_REQ-1:0]            rsp_data_tvalid,
    input  logic [NUM_REQ-1:0]            rsp_data_tready,
`ifdef CACHE_ARB_PERF_EN
    input  logic                          perf_clr,
    output logic [NUM_REQ*32-1:0]         grant_cnt,
`endif
    output logic [TAGS_WIDTH-1:0]         cache_addr_tdata,
    output logic                          cache_addr_tvalid,
    input  logic                          cache_addr_tready,
    input  logic [DATA_WIDTH-1:0]         cache_data_tdata,
    input  logic                          cache_data_tvalid,
    output logic                          cache_data_tready,
    output logic [$clog2(ORDER_DEPTH+1)-1:0] outstanding,
    output logic                          orphan_err
);
    localparam int PTRW = $clog2(ORDER_DEPTH);
    localparam int CNTW = $clog2(ORDER_DEPTH+1);

    logic [NUM_REQ-1:0][TAGS_WIDTH-1:0] req_tags;
    logic [IDW-1:0]  last_grant, winner, idx, head;
    logic            any_vld, load_ok, accept, pop, fifo_empty;
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [IDW-1:0]  ord_mem [ORDER_DEPTH];

    assign req_tags = req_addr_tdata;

    // Rotating priority: search begins just after the last winner.
    always_comb begin
        any_vld = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (!any_vld && req_addr_tvalid[idx]) begin
                any_vld = 1'b1;
                winner  = idx;
            end
        end
    end

    assign fifo_empty = (outstanding == '0);
    assign head       = ord_mem[rd_ptr];
    assign pop        = !fifo_empty && cache_data_tvalid && rsp_data_tready[head];
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign load_ok    = !rst && (!cache_addr_tvalid || cache_addr_tready) &&
                        ((outstanding - CNTW'(pop)) < CNTW'(ORDER_DEPTH));
    assign accept     = load_ok && any_vld;

    assign req_addr_tready   = accept ? (NUM_REQ'(1) << winner) : '0;
    assign rsp_data_tdata    = cache_data_tdata;
    assign rsp_data_tvalid   = (!fifo_empty && cache_data_tvalid) ? (NUM_REQ'(1) << head) : '0;
    // Beats with nothing outstanding are swallowed and flagged as orphans.
    assign cache_data_tready = rst ? 1'b0 : (fifo_empty ? 1'b1 : rsp_data_tready[head]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_addr_tvalid <= 1'b0;
            cache_addr_tdata  <= '0;
            last_grant        <= IDW'(NUM_REQ-1);
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            outstanding       <= '0;
            orphan_err        <= 1'b0;
        end else begin
            if (accept) begin
                cache_addr_tvalid <= 1'b1;
                cache_addr_tdata  <= req_tags[winner];
                last_grant        <= winner;
                wr_ptr            <= wr_ptr + 1'b1;
            end else if (cache_addr_tready) begin
                cache_addr_tvalid <= 1'b0;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            outstanding <= outstanding + CNTW'(accept) - CNTW'(pop);
            if (fifo_empty && cache_data_tvalid)
                orphan_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            ord_mem[wr_ptr] <= winner;
    end

`ifdef CACHE_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] cnt_q;
    assign grant_cnt = cnt_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_q[g] <= '0;
            else if (perf_clr)
                cnt_q[g] <= '0;
            else if (req_addr_tready[g] && req_addr_tvalid[g] && (cnt_q[g] != 32'hFFFF_FFFF))
                cnt_q[g] <= cnt_q[g] + 32'd1;
        end
    end
`endif
endmodule
